// File: rtl/instr_feeder_pkg.sv
// Shared opcode constants, opcode field position and feeder FSM state encoding.
// Imported by the feeder and by the control unit.
package instr_feeder_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    ISSUE,
    IMM_FETCH,
    IMM,
    WAIT_DONE,
    HALTED
  } state_t;

endpackage

// File: rtl/instr_feeder_if.sv
// Program-memory plus Run/DIN/Done bus between feeder, memory and control unit.
// master = feeder side; slave = memory/processor side.
interface instr_feeder_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 9
);
  logic              Start;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] MemData;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;
  logic              Busy;
  logic              Halted;
  logic              Error;

  modport master (
    input  Start, MemData, Done,
    output Addr, DIN, Run, Busy, Halted, Error
  );

  modport slave (
    output Start, MemData, Done,
    input  Addr, DIN, Run, Busy, Halted, Error
  );
endinterface

// File: rtl/instr_feeder_pc.sv
// Program counter: synchronous reset, load, increment enable, wraps modulo 2^ADDR_W.
// Latency: 1 cycle; no backpressure (load has priority over inc).
// Sync reset, active-high.
module instr_feeder_pc #(
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_feeder.sv
// Walks program memory from address 0, issuing each word on DIN with a one-cycle Run pulse.
// Latency: Start to first Run 3 cycles; Run-to-Run >= 4 (mv) / 6 (mvi).
// Backpressure: holds in WAIT_DONE until Done; INSTR_FEEDER_DONE_TIMEOUT_EN adds a sticky Done timeout.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 9,
  parameter int LAST_ADDR    = 31,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic           Clock,
  input  logic           Reset,
  instr_feeder_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              pc_ld;
  logic              pc_inc;
  logic              last_word;
  logic              at_end;
  logic [2:0]        mem_op;
  logic [2:0]        din_op;

`ifdef INSTR_FEEDER_DONE_TIMEOUT_EN
  localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign mem_op = bus.MemData[OP_HI:OP_LO];
  assign din_op = bus.DIN[OP_HI:OP_LO];
  assign pc_nxt = pc + ADDR_W'(1);
  // An mvi sitting at LAST_ADDR has already advanced PC past it, so remember where it came from.
  assign at_end = (pc == LAST_PC) || last_word;

  always_comb begin
    pc_ld  = 1'b0;
    pc_inc = 1'b0;
    if (state == IDLE && bus.Start) begin
      pc_ld = 1'b1;
    end
    if (state == ISSUE && din_op == OP_MVI) begin
      pc_inc = 1'b1;
    end
    if (state == WAIT_DONE && bus.Done && !at_end) begin
      pc_inc = 1'b1;
    end
  end

  instr_feeder_pc #(.ADDR_W(ADDR_W)) u_pc (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (pc_ld),
    .load_val ('0),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      bus.Addr   <= '0;
      bus.DIN    <= '0;
      bus.Run    <= 1'b0;
      bus.Busy   <= 1'b0;
      bus.Halted <= 1'b0;
      bus.Error  <= 1'b0;
      last_word  <= 1'b0;
`ifdef INSTR_FEEDER_DONE_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      bus.Run <= 1'b0;
      case (state)
        IDLE: begin
          bus.Addr <= pc;
          if (bus.Start) begin
            state    <= FETCH;
            bus.Addr <= '0;
            bus.Busy <= 1'b1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          last_word <= (pc == LAST_PC);
          if (mem_op == OP_HALT) begin
            state      <= HALTED;
            bus.Busy   <= 1'b0;
            bus.Halted <= 1'b1;
          end else begin
            state   <= ISSUE;
            bus.DIN <= bus.MemData;
            bus.Run <= 1'b1;
            // Present the immediate address during ISSUE so the word is on DIN by IMM.
            if (mem_op == OP_MVI) begin
              bus.Addr <= pc_nxt;
            end
          end
        end
        ISSUE: begin
          state <= (din_op == OP_MVI) ? IMM_FETCH : WAIT_DONE;
`ifdef INSTR_FEEDER_DONE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        IMM_FETCH: begin
          state   <= IMM;
          bus.DIN <= bus.MemData;
        end
        IMM: begin
          state <= WAIT_DONE;
`ifdef INSTR_FEEDER_DONE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT_DONE: begin
          if (bus.Done) begin
            if (at_end) begin
              state      <= HALTED;
              bus.Busy   <= 1'b0;
              bus.Halted <= 1'b1;
            end else begin
              state    <= FETCH;
              bus.Addr <= pc_nxt;
            end
          end
`ifdef INSTR_FEEDER_DONE_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(DONE_TIMEOUT - 1)) begin
            state      <= HALTED;
            bus.Busy   <= 1'b0;
            bus.Halted <= 1'b1;
            bus.Error  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: cycle table on a mixed program plus hand sequences
// for Done stall, reset during IMM, LAST_ADDR halt and Done timeout.
module tb_instr_feeder;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  instr_feeder_if #(.ADDR_W(5), .DATA_W(9)) ifa ();
  instr_feeder_if #(.ADDR_W(5), .DATA_W(9)) ifb ();

  instr_feeder #(.ADDR_W(5), .DATA_W(9), .LAST_ADDR(31), .DONE_TIMEOUT(15)) dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (ifa)
  );

  instr_feeder #(.ADDR_W(5), .DATA_W(9), .LAST_ADDR(3), .DONE_TIMEOUT(15)) dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (ifb)
  );

  logic [8:0] mem_a [32];
  logic [8:0] mem_b [32];

  always @(posedge Clock) begin
    ifa.MemData <= mem_a[ifa.Addr];
    ifb.MemData <= mem_b[ifb.Addr];
  end

  int errors = 0;
  int checks = 0;

  logic [8:0] din_log  [8];
  logic [4:0] addr_log [8];

  typedef struct {
    logic       start;
    logic       done;
    logic [4:0] addr;
    logic [8:0] din;
    logic       run;
    logic       busy;
    logic       halted;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    ifa.Start = 1'b0;
    ifa.Done  = 1'b0;
    ifb.Start = 1'b0;
    ifb.Done  = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic wait_run_a(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (ifa.Run) ok = 1'b1;
    end
  endtask

  // Done held high throughout: only its first WAIT_DONE cycle matters.
  task automatic run_b(output int runs);
    runs      = 0;
    ifb.Start = 1'b1;
    ifb.Done  = 1'b1;
    for (int k = 0; k < 80 && !ifb.Halted; k++) begin
      tick();
      if (ifb.Run) begin
        if (runs < 8) begin
          din_log[runs]  = ifb.DIN;
          addr_log[runs] = ifb.Addr;
        end
        runs++;
      end
    end
    ifb.Start = 1'b0;
    ifb.Done  = 1'b0;
  endtask

  initial begin
    bit ok;
    int runs;

    // mv R1,R2 ; mvi R3,#05A ; add R1,R3 ; halt
    vt[0]  = '{1'b1, 1'b0, 5'd0, 9'h000, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 5'd0, 9'h000, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 5'd0, 9'h00A, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 5'd0, 9'h00A, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 5'd1, 9'h00A, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 5'd1, 9'h00A, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 5'd2, 9'h058, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 5'd2, 9'h058, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 5'd2, 9'h05A, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 5'd2, 9'h05A, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 5'd3, 9'h05A, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 5'd3, 9'h05A, 1'b0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 5'd3, 9'h08B, 1'b1, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b0, 5'd3, 9'h08B, 1'b0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b1, 5'd4, 9'h08B, 1'b0, 1'b1, 1'b0};
    vt[15] = '{1'b0, 1'b0, 5'd4, 9'h08B, 1'b0, 1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b0, 5'd4, 9'h08B, 1'b0, 1'b0, 1'b1};
    vt[17] = '{1'b1, 1'b1, 5'd4, 9'h08B, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 9'h1C0;
      mem_b[i] = 9'h005;
    end
    mem_a[0] = 9'h00A;
    mem_a[1] = 9'h058;
    mem_a[2] = 9'h05A;
    mem_a[3] = 9'h08B;

    do_reset();
    check("reset Addr", ifa.Addr, 0);
    check("reset DIN", ifa.DIN, 0);
    check("reset Run", ifa.Run, 0);
    check("reset Busy", ifa.Busy, 0);
    check("reset Halted", ifa.Halted, 0);
    check("reset Error", ifa.Error, 0);

    for (int i = 0; i < 18; i++) begin
      ifa.Start = vt[i].start;
      ifa.Done  = vt[i].done;
      tick();
      check($sformatf("vec%0d Addr", i), ifa.Addr, vt[i].addr);
      check($sformatf("vec%0d DIN", i), ifa.DIN, vt[i].din);
      check($sformatf("vec%0d Run", i), ifa.Run, vt[i].run);
      check($sformatf("vec%0d Busy", i), ifa.Busy, vt[i].busy);
      check($sformatf("vec%0d Halted", i), ifa.Halted, vt[i].halted);
    end
    ifa.Start = 1'b0;
    ifa.Done  = 1'b0;

    // mv then halt, with Done withheld for 10 WAIT_DONE cycles
    mem_a[0] = 9'h00A;
    mem_a[1] = 9'h1C0;
    do_reset();
    ifa.Start = 1'b1;
    wait_run_a(ok);
    check("stall run seen", ok, 1);
    check("stall issue DIN", ifa.DIN, 9'h00A);
    ifa.Start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tick();
      check($sformatf("stall%0d Addr", k), ifa.Addr, 0);
      check($sformatf("stall%0d DIN", k), ifa.DIN, 9'h00A);
      check($sformatf("stall%0d Run", k), ifa.Run, 0);
    end
    ifa.Done = 1'b1;
    tick();
    ifa.Done = 1'b0;
    check("stall fetch Addr", ifa.Addr, 1);
    check("stall fetch Busy", ifa.Busy, 1);
    tick();
    tick();
    check("stall Halted", ifa.Halted, 1);
    check("stall Busy", ifa.Busy, 0);
    check("stall halt Addr", ifa.Addr, 1);
    ifa.Start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("halted%0d Run", k), ifa.Run, 0);
    end
    check("halted stays", ifa.Halted, 1);
    ifa.Start = 1'b0;

    // mvi, reset during IMM, then restart from address 0
    mem_a[0] = 9'h058;
    mem_a[1] = 9'h05A;
    mem_a[2] = 9'h1C0;
    do_reset();
    ifa.Start = 1'b1;
    wait_run_a(ok);
    check("mvi run seen", ok, 1);
    check("mvi issue DIN", ifa.DIN, 9'h058);
    ifa.Start = 1'b0;
    tick();
    check("imm_fetch DIN", ifa.DIN, 9'h058);
    check("imm_fetch Addr", ifa.Addr, 1);
    tick();
    check("imm DIN", ifa.DIN, 9'h05A);
    check("imm Run", ifa.Run, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst Addr", ifa.Addr, 0);
    check("midrst DIN", ifa.DIN, 0);
    check("midrst Run", ifa.Run, 0);
    check("midrst Busy", ifa.Busy, 0);
    ifa.Start = 1'b1;
    wait_run_a(ok);
    check("restart run seen", ok, 1);
    check("restart DIN", ifa.DIN, 9'h058);
    ifa.Start = 1'b0;
    tick();
    tick();
    tick();
    ifa.Done = 1'b1;
    tick();
    ifa.Done = 1'b0;
    check("after mvi fetch Addr", ifa.Addr, 2);
    tick();
    tick();
    check("after mvi Halted", ifa.Halted, 1);

    // LAST_ADDR=3, four mv words, no halt word
    mem_b[0] = 9'h00A;
    mem_b[1] = 9'h011;
    mem_b[2] = 9'h01A;
    mem_b[3] = 9'h023;
    do_reset();
    run_b(runs);
    check("last runs", runs, 4);
    check("last Halted", ifb.Halted, 1);
    check("last Busy", ifb.Busy, 0);
    check("last Addr", ifb.Addr, 3);
    check("last din0", din_log[0], 9'h00A);
    check("last din3", din_log[3], 9'h023);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("last addr%0d", k), addr_log[k], k);
    end

    // mvi at LAST_ADDR takes its immediate from LAST_ADDR+1, then halts
    mem_b[3] = 9'h058;
    mem_b[4] = 9'h07E;
    do_reset();
    run_b(runs);
    check("lastmvi runs", runs, 4);
    check("lastmvi issue DIN", din_log[3], 9'h058);
    check("lastmvi Halted", ifb.Halted, 1);
    check("lastmvi DIN", ifb.DIN, 9'h07E);
    check("lastmvi Addr", ifb.Addr, 4);

    // Done never returned
    mem_a[0] = 9'h00A;
    do_reset();
    ifa.Start = 1'b1;
    wait_run_a(ok);
    check("tmo run seen", ok, 1);
    ifa.Start = 1'b0;
    tick();
    for (int k = 0; k < 14; k++) tick();
    check("tmo-1 Halted", ifa.Halted, 0);
    check("tmo-1 Error", ifa.Error, 0);
    tick();
`ifdef INSTR_FEEDER_DONE_TIMEOUT_EN
    check("tmo Error", ifa.Error, 1);
    check("tmo Halted", ifa.Halted, 1);
    check("tmo Busy", ifa.Busy, 0);
`else
    check("tmo Error", ifa.Error, 0);
    check("tmo Halted", ifa.Halted, 0);
    check("tmo Busy", ifa.Busy, 1);
`endif
    for (int k = 0; k < 5; k++) tick();
`ifdef INSTR_FEEDER_DONE_TIMEOUT_EN
    check("tmo Error sticky", ifa.Error, 1);
`else
    check("tmo Error late", ifa.Error, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
